// File: rtl/systolic_ctrl.sv
// Job sequencer for an M x P systolic array: clears the PEs, streams K operand reads
// through per-lane skew registers, waits out the pipeline, then captures the result.
module systolic_ctrl #(
  parameter int unsigned BW     = 16,
  parameter int unsigned M      = 3,
  parameter int unsigned N      = 4,
  parameter int unsigned P      = 5,
  parameter int unsigned PE_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(N+1)-1:0]      k_len,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [$clog2(N)-1:0]        rd_k,
  input  logic [M-1:0][BW-1:0]        a_col,
  input  logic [P-1:0][BW-1:0]        b_row,
  output logic                        arr_rst_n,
  output logic [M-1:0][BW-1:0]        iRow,
  output logic [P-1:0][BW-1:0]        iCol,
  input  logic [M-1:0][P-1:0][BW-1:0] oRes,
  output logic [M-1:0][P-1:0][BW-1:0] res
);

  localparam int unsigned KW       = $clog2(N + 1);
  localparam int unsigned RkW      = $clog2(N);
  localparam int unsigned DrainCyc = M + P - 1 + PE_LAT;
  localparam int unsigned CW       = $clog2(DrainCyc + 1);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

  state_e                        state_q, state_d;
  logic [KW-1:0]                 klen_q, klen_d;
  logic [RkW-1:0]                k_q, k_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          rd_vld_q;
  logic [M-1:0][P-1:0][BW-1:0]   res_q;
  logic [M-1:0][BW-1:0]          row_in;
  logic [P-1:0][BW-1:0]          col_in;

  always_comb begin
    state_d   = state_q;
    klen_d    = klen_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    rd_en     = 1'b0;
    arr_rst_n = ~rst;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          klen_d  = (k_len > KW'(N)) ? KW'(N) : k_len;
        end
      end
      StClear: begin
        arr_rst_n = 1'b0;
        if (klen_q != '0) begin
          state_d = StFeed;
          k_d     = '0;
        end else begin
          state_d = StDrain;
          cnt_d   = CW'(DrainCyc - 1);
        end
      end
      StFeed: begin
        rd_en = 1'b1;
        if (KW'(k_q) == klen_q - KW'(1)) begin
          state_d = StDrain;
          k_d     = '0;
          cnt_d   = CW'(DrainCyc - 1);
        end else begin
          k_d = k_q + RkW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      klen_q   <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      klen_q   <= klen_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_en;
      if (state_q == StDone) res_q <= oRes;
    end
  end

  assign rd_k = k_q;
  assign res  = res_q;

  // Operand data is only trusted the cycle after a read; zeros fill every other slot.
  always_comb begin
    row_in = rd_vld_q ? a_col : '0;
    col_in = rd_vld_q ? b_row : '0;
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    if (i == 0) begin : g_pass
      assign iRow[i] = row_in[i];
    end else begin : g_sr
      logic [BW-1:0] sr_q [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int n = 0; n < i; n++) sr_q[n] <= '0;
        end else begin
          sr_q[0] <= row_in[i];
          for (int n = 1; n < i; n++) sr_q[n] <= sr_q[n-1];
        end
      end
      assign iRow[i] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_col
    if (j == 0) begin : g_pass
      assign iCol[j] = col_in[j];
    end else begin : g_sr
      logic [BW-1:0] sr_q [j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int n = 0; n < j; n++) sr_q[n] <= '0;
        end else begin
          sr_q[0] <= col_in[j];
          for (int n = 1; n < j; n++) sr_q[n] <= sr_q[n-1];
        end
      end
      assign iCol[j] = sr_q[j-1];
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: jobs push expected reads/done cycles into queues and a
// negedge monitor compares handshakes, skewed feeds, busy/clear windows and captured results.
module tb_systolic_ctrl;

  localparam int unsigned BW     = 16;
  localparam int unsigned M      = 3;
  localparam int unsigned N      = 4;
  localparam int unsigned P      = 5;
  localparam int unsigned PE_LAT = 1;
  localparam int unsigned KW     = $clog2(N + 1);
  localparam int unsigned RkW    = $clog2(N);
  localparam int          DrainCyc = M + P - 1 + PE_LAT;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [KW-1:0]               k_len = '0;
  logic                        busy, done, rd_en, arr_rst_n;
  logic [RkW-1:0]              rd_k;
  logic [M-1:0][BW-1:0]        a_col = '0;
  logic [P-1:0][BW-1:0]        b_row = '0;
  logic [M-1:0][BW-1:0]        iRow;
  logic [P-1:0][BW-1:0]        iCol;
  logic [M-1:0][P-1:0][BW-1:0] oRes = '0;
  logic [M-1:0][P-1:0][BW-1:0] res;

  systolic_ctrl #(
    .BW(BW), .M(M), .N(N), .P(P), .PE_LAT(PE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_k(rd_k),
    .a_col(a_col), .b_row(b_row), .arr_rst_n(arr_rst_n),
    .iRow(iRow), .iCol(iCol), .oRes(oRes), .res(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int k;} rd_ev_t;

  int      n_chk = 0;
  int      n_fail = 0;
  logic    chk_en = 1'b0;
  logic    in_rst = 1'b0;
  rd_ev_t  rd_q[$];
  int      done_q[$];
  int      job_c = -1;
  int      job_k = 0;
  logic [BW-1:0] a_mem [M][N];
  logic [BW-1:0] b_mem [N][P];
  logic [M-1:0][P-1:0][BW-1:0] res_exp = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++) for (int k = 0; k < N; k++) a_mem[i][k] = BW'($urandom);
    for (int k = 0; k < N; k++) for (int j = 0; j < P; j++) b_mem[k][j] = BW'($urandom);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < M; i++) for (int k = 0; k < N; k++)
      a_mem[i][k] = (i == k) ? 16'h3F80 : 16'h0000;
    for (int k = 0; k < N; k++) for (int j = 0; j < P; j++)
      b_mem[k][j] = (k == j) ? 16'h3F80 : 16'h0000;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < M; i++) for (int k = 0; k < N; k++) a_mem[i][k] = BW'(k * M + i + 1);
    for (int k = 0; k < N; k++) for (int j = 0; j < P; j++) b_mem[k][j] = BW'(k * P + j + 1);
  endtask

  // Reference job: clear 1, feed K, drain DrainCyc, done 1; returns the next idle cycle.
  task automatic issue(input int klen, output int nxt);
    int kk;
    kk    = (klen > N) ? N : klen;
    start = 1'b1;
    k_len = KW'(klen);
    job_c = cyc;
    job_k = kk;
    for (int k = 0; k < kk; k++) rd_q.push_back('{c: cyc + 2 + k, k: k});
    done_q.push_back(cyc + kk + DrainCyc + 2);
    nxt = cyc + kk + DrainCyc + 3;
  endtask

  task automatic run_job(input int klen);
    int nxt;
    issue(klen, nxt);
    step();
    start = 1'b0;
    k_len = KW'($urandom);
    goto_cyc(nxt);
  endtask

  // Operand buffer: answers each read one cycle later, otherwise drives junk.
  initial begin
    logic           v;
    logic [RkW-1:0] rk;
    forever begin
      @(negedge clk);
      v  = rd_en;
      rk = rd_k;
      @(posedge clk);
      #1;
      for (int i = 0; i < M; i++) a_col[i] = v ? a_mem[i][rk] : BW'($urandom);
      for (int j = 0; j < P; j++) b_row[j] = v ? b_mem[rk][j] : BW'($urandom);
      for (int i = 0; i < M; i++) for (int j = 0; j < P; j++) oRes[i][j] = BW'($urandom);
    end
  end

  task automatic monitor_cycle();
    logic                 exp_busy, exp_arn, exp_rd, exp_done;
    logic [M-1:0][BW-1:0] row_e;
    logic [P-1:0][BW-1:0] col_e;
    int                   k;
    exp_busy = (job_c >= 0) && (cyc >= job_c + 1) && (cyc <= job_c + job_k + DrainCyc + 2);
    check("busy", busy, exp_busy);
    exp_arn = !((job_c >= 0) && (cyc == job_c + 1));
    check("arr_rst_n", arr_rst_n, exp_arn);
    exp_rd = (rd_q.size() > 0) && (rd_q[0].c == cyc);
    check("rd_en", rd_en, exp_rd);
    if (exp_rd) begin
      check("rd_k", rd_k, rd_q[0].k);
      rd_q.delete(0);
    end
    exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
    check("done", done, exp_done);
    row_e = '0;
    col_e = '0;
    if (job_c >= 0) begin
      for (int i = 0; i < M; i++) begin
        k = cyc - (job_c + 2) - 1 - i;
        if (k >= 0 && k < job_k) row_e[i] = a_mem[i][k];
      end
      for (int j = 0; j < P; j++) begin
        k = cyc - (job_c + 2) - 1 - j;
        if (k >= 0 && k < job_k) col_e[j] = b_mem[k][j];
      end
    end
    check("iRow", iRow, row_e);
    check("iCol", iCol, col_e);
    check("res", res, res_exp);
    if (exp_done) begin
      res_exp = oRes;
      done_q.delete(0);
    end
  endtask

  always @(negedge clk) if (chk_en && !in_rst) monitor_cycle();

  initial begin
    int nxt, nxt2;
    fill_random();
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_k", rd_k, '0);
    check("rst_iRow", iRow, '0);
    check("rst_iCol", iCol, '0);
    check("rst_res", res, '0);
    check("rst_arr_rst_n", arr_rst_n, 1'b0);
    step();
    rst    = 1'b0;
    chk_en = 1'b1;
    step();

    fill_identity();
    run_job(3);
    fill_seq();
    run_job(4);
    fill_random();
    run_job(0);

    // Start held high across two clamped jobs; the second may only start after DONE.
    fill_random();
    issue(7, nxt);
    goto_cyc(nxt);
    fill_random();
    issue(7, nxt2);
    step();
    start = 1'b0;
    goto_cyc(nxt2);

    repeat (6) begin
      fill_random();
      repeat ($urandom_range(0, 3)) step();
      run_job(int'($urandom_range(0, 7)));
    end

    // Reset in the third FEED cycle abandons the job.
    fill_random();
    issue(4, nxt);
    step();
    start = 1'b0;
    goto_cyc(job_c + 4);
    rst    = 1'b1;
    in_rst = 1'b1;
    step();
    rd_q.delete();
    done_q.delete();
    job_c   = -1;
    res_exp = '0;
    rst     = 1'b0;
    in_rst  = 1'b0;
    repeat (14) step();

    fill_random();
    run_job(2);
    repeat (4) step();
    check("rd_q_drained", rd_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
